// File: rtl/round_judge.sv
// round_judge: classifies each timed round as HIT/MISS/WRONG and keeps score and combo.
// Define ROUND_JUDGE_PERFECT_BONUS_EN to give fast hits a +2 score bonus.
module round_judge #(
   parameter int KEYS          = 4,
   parameter int TIME_W        = 4,
   parameter int SCORE_W       = 8,
   parameter int PERFECT_LIMIT = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               gameState,
   input  logic               window,
   input  logic               tick,
   input  logic [KEYS-1:0]    target,
   input  logic [KEYS-1:0]    keys,
   input  logic               result_ack,
   output logic               result_valid,
   output logic [1:0]         result_code,
   output logic [TIME_W-1:0]  reaction,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] combo,
   output logic               overrun
);

`ifdef ROUND_JUDGE_PERFECT_BONUS_EN
   localparam logic BONUS = 1'b1;
`else
   localparam logic BONUS = 1'b0;
`endif

   localparam logic [1:0] C_NONE  = 2'b00;
   localparam logic [1:0] C_HIT   = 2'b01;
   localparam logic [1:0] C_MISS  = 2'b10;
   localparam logic [1:0] C_WRONG = 2'b11;

   localparam logic [TIME_W-1:0]  T_MAX = '1;
   localparam logic [SCORE_W-1:0] S_MAX = '1;
   localparam logic [TIME_W-1:0]  P_LIM = TIME_W'(PERFECT_LIMIT);

   typedef enum logic [1:0] {
      S_IDLE, S_ARMED, S_WAIT, S_REPORT
   } state_t;

   state_t              state_q, state_d;
   logic [KEYS-1:0]     k1_q, k2_q;
   logic                win_q;
   logic [KEYS-1:0]     tgt_q, tgt_d;
   logic [TIME_W-1:0]   react_q, react_d;
   logic [1:0]          code_q, code_d;
   logic [SCORE_W-1:0]  score_q, score_d;
   logic [SCORE_W-1:0]  combo_q, combo_d;
   logic                ovr_q, ovr_d;

   logic [KEYS-1:0]     press;
   logic                rise, fall;
   logic                enter, perfect;
   logic [SCORE_W:0]    inc, sum;

   assign press = k1_q & ~k2_q;
   assign rise  = window & ~win_q;
   assign fall  = ~window & win_q;

   // State and datapath registers, including key/window history
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         k1_q    <= '0;
         k2_q    <= '0;
         win_q   <= 1'b0;
         tgt_q   <= '0;
         react_q <= '0;
         code_q  <= C_NONE;
         score_q <= '0;
         combo_q <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k1_q    <= keys;
         k2_q    <= k1_q;
         win_q   <= window;
         tgt_q   <= tgt_d;
         react_q <= react_d;
         code_q  <= code_d;
         score_q <= score_d;
         combo_q <= combo_d;
         ovr_q   <= ovr_d;
      end
   end

   // Next state, round classification and reaction timing
   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      react_d = react_q;
      code_d  = code_q;
      ovr_d   = ovr_q;
      if (!gameState) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (rise) begin
                  tgt_d   = target;
                  react_d = '0;
                  code_d  = C_NONE;
                  state_d = S_ARMED;
               end
            end
            S_ARMED: begin
               if (press != '0) begin
                  code_d  = (press == tgt_q) ? C_HIT : C_WRONG;
                  state_d = fall ? S_REPORT : S_WAIT;
               end else begin
                  if (tick && react_q != T_MAX)
                     react_d = react_q + 1'b1;
                  if (fall) begin
                     code_d  = (tgt_q != '0) ? C_MISS : C_HIT;
                     state_d = S_REPORT;
                  end
               end
            end
            S_WAIT: begin
               if (fall)
                  state_d = S_REPORT;
            end
            S_REPORT: begin
               if (rise && !result_ack) begin
                  ovr_d   = 1'b1;
                  tgt_d   = target;
                  react_d = '0;
                  code_d  = C_NONE;
                  state_d = S_ARMED;
               end else if (result_ack) begin
                  state_d = S_IDLE;
               end
            end
         endcase
      end
   end

   // Score/combo update once, as the FSM enters REPORT
   always_comb begin
      score_d = score_q;
      combo_d = combo_q;
      enter   = (state_d == S_REPORT) && (state_q != S_REPORT);
      perfect = BONUS && (tgt_q != '0) && (react_d < P_LIM);
      inc     = perfect ? (SCORE_W+1)'(2) : (SCORE_W+1)'(1);
      sum     = {1'b0, score_q} + inc;
      if (enter) begin
         if (code_d == C_HIT) begin
            score_d = sum[SCORE_W] ? S_MAX : sum[SCORE_W-1:0];
            combo_d = (combo_q == S_MAX) ? S_MAX : combo_q + 1'b1;
         end else begin
            combo_d = '0;
         end
      end
   end

   // Result outputs; code is only presented while a result is pending
   always_comb begin
      result_valid = (state_q == S_REPORT);
      result_code  = result_valid ? code_q : C_NONE;
      reaction     = react_q;
      score        = score_q;
      combo        = combo_q;
      overrun      = ovr_q;
   end

endmodule

// File: doc/round_judge.md
Name: round_judge

Overview:
- Consumer end of the round-timing interface.
- Receives the round phase signal (high = player response window) and the per-round target key pattern; watches the player keys.
- Classifies each round as HIT, MISS or WRONG, measures reaction time in ticks, and keeps score and combo.
- Hands each result to the display/scoring logic over a valid/ack handshake.

Parameters:
- KEYS, 4, number of player keys / target bits
- TIME_W, 4, reaction counter width, in tick units
- SCORE_W, 8, score and combo counter width
- PERFECT_LIMIT, 2, reaction tick count strictly below which a hit is "perfect" (used only with the optional feature)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clears all state
- gameState  in  1  game running; low forces IDLE
- window  in  1  round phase from the timing block; high = response window open
- tick  in  1  one-cycle time-unit pulse
- target  in  KEYS  expected key pattern; sampled on window rising edge
- keys  in  KEYS  raw player keys, active-high
- result_ack  in  1  consumer accepts result
- result_valid  out  1  result pending
- result_code  out  2  00 none, 01 HIT, 10 MISS, 11 WRONG
- reaction  out  TIME_W  ticks from window open to first press
- score  out  SCORE_W  saturating hit count
- combo  out  SCORE_W  saturating consecutive-hit count
- overrun  out  1  sticky: a result was displaced before ack

Behaviour:
- Reset: all outputs 0; FSM in IDLE; key/window history registers 0.
- Input conditioning:
  - keys pass through two flops.
  - press = k1 & ~k2 (rising edge, per bit).
  - window is registered once, giving rise and fall strobes. Latency from a pin edge to FSM action is 2 cycles for keys and 1 cycle for window.
- IDLE:
  - result_code 00.
  - On window rise with gameState=1: latch target into tgt_q, clear reaction, go to ARMED.
- ARMED:
  - reaction increments on tick and saturates at 2^TIME_W-1.
  - First cycle with press≠0: code = HIT if press==tgt_q, else WRONG; freeze reaction; go to WAIT_END. A multi-key chord must arrive on the same edge cycle to match.
  - Window fall with no press: MISS if tgt_q≠0; HIT (rest round) if tgt_q==0; go to REPORT.
  - tgt_q==0 and any press: WRONG.
  - Press and window fall in the same cycle: the press is evaluated and the FSM goes straight to REPORT.
- WAIT_END:
  - Further presses are ignored.
  - On window fall, go to REPORT.
- REPORT:
  - Score and combo update exactly once, on the entry cycle.
  - HIT: score+1 and combo+1, both saturating at all-ones.
  - MISS or WRONG: combo=0, score unchanged.
  - result_valid=1 from the entry cycle until result_ack is sampled high; then go to IDLE and drop result_valid on the next cycle.
  - result_code and reaction are held stable while result_valid=1.
- Window rise while in REPORT without ack:
  - Set overrun (sticky until reset).
  - Drop result_valid.
  - Latch the new target and go to ARMED.
- result_ack outside REPORT is ignored.
- gameState=0 in any state:
  - Next cycle is IDLE, result_valid=0.
  - score and combo are held (not cleared).
  - Any in-flight round is discarded without a score update.
- Reset asserted mid-round overrides everything in that cycle.

Optional Feature:
- Macro: ROUND_JUDGE_PERFECT_BONUS_EN.
- Defined: a HIT with reaction < PERFECT_LIMIT adds 2 to score (saturating); combo still increments by 1. Rest-round HITs always add 1.
- Undefined: every HIT adds 1. PERFECT_LIMIT is unused.

Test Plan:
- Hit: reset; gameState=1; window rise with target=0100; 3 ticks; keys=0100; window fall -> result_valid=1, code 01, reaction=3, score=1, combo=1; ack -> valid=0 next cycle.
- Miss then wrong: after 2 hits (combo=2), a round with no press -> code 10, combo=0, score=2. Next round, target=0010 and keys=0001 -> code 11, score=2.
- Rest round and saturation: target=0000 with no press -> code 01. Preload score to 255 via 255 hits -> further hit keeps score=255.
- Overrun: result pending without ack, then a new window rise -> overrun=1, result_valid=0, FSM armed. The following round reports normally and overrun stays 1.
- Abort: gameState low mid-ARMED -> IDLE, no result, score and combo unchanged. Reset mid-REPORT -> all outputs 0 next cycle.
- Bonus (macro defined): press at reaction=1 with PERFECT_LIMIT=2 -> score+2. Press at reaction=2 -> score+1. Macro undefined: both cases -> +1.
